// File: rtl/vmask_reduce.sv
// vmask_reduce: pipelined mask-reduction unit (vcpop.m / vfirst.m).
//
// A mask is streamed in REQ_DATA_WIDTH-bit beats. Each valid beat is
// qualified (optional v0 AND, tail trim to in_nbits) and then reduced. One
// scalar result per operation is emitted on out_vec/out_valid, tagged with
// the end beat's address.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   in_valid   beat valid; low cycles are bubbles and change no state
//   in_end     last beat of the operation
//   in_op      0 = cpop, 1 = first
//   in_m0      source mask beat
//   in_v0      v0 mask beat, applied when in_vm = 0
//   in_vm      1 = unmasked
//   in_nbits   active low-order bits in this beat (clamped to REQ_DATA_WIDTH)
//   in_addr    write-back address, taken from the end beat
//   out_vec    result (count, first index, or all-ones when none found)
//   out_addr   address of the end beat
//   out_valid  one-cycle result strobe
module vmask_reduce #(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int REQ_ADDR_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_end,
  input  logic                              in_op,
  input  logic [REQ_DATA_WIDTH-1:0]         in_m0,
  input  logic [REQ_DATA_WIDTH-1:0]         in_v0,
  input  logic                              in_vm,
  input  logic [$clog2(REQ_DATA_WIDTH):0]   in_nbits,
  input  logic [REQ_ADDR_WIDTH-1:0]         in_addr,
  output logic [RESP_DATA_WIDTH-1:0]        out_vec,
  output logic [REQ_ADDR_WIDTH-1:0]         out_addr,
  output logic                              out_valid
);

  localparam int NBW  = $clog2(REQ_DATA_WIDTH) + 1;
  localparam int IDXW = (REQ_DATA_WIDTH > 1) ? $clog2(REQ_DATA_WIDTH) : 1;

  // ---------------------------------------------------------------------
  // Beat qualification
  // ---------------------------------------------------------------------
  logic [NBW-1:0]            nbits_c;
  logic [REQ_DATA_WIDTH-1:0] keep;
  logic [REQ_DATA_WIDTH-1:0] eff;

  always_comb begin
    nbits_c = (in_nbits > NBW'(REQ_DATA_WIDTH)) ? NBW'(REQ_DATA_WIDTH) : in_nbits;
    keep    = '0;
    for (int unsigned i = 0; i < REQ_DATA_WIDTH; i++) begin
      keep[i] = (i < 32'(nbits_c));
    end
    eff = in_m0 & (in_vm ? {REQ_DATA_WIDTH{1'b1}} : in_v0) & keep;
  end

  // ---------------------------------------------------------------------
  // S1: qualified beat register
  // ---------------------------------------------------------------------
  logic                      s1_valid;
  logic [REQ_DATA_WIDTH-1:0] s1_eff;
  logic                      s1_op;
  logic                      s1_end;
  logic [REQ_ADDR_WIDTH-1:0] s1_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_eff   <= '0;
      s1_op    <= 1'b0;
      s1_end   <= 1'b0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_eff  <= eff;
        s1_op   <= in_op;
        s1_end  <= in_end;
        s1_addr <= in_addr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2: per-beat popcount, lowest set bit, beat number
  // ---------------------------------------------------------------------
  logic [NBW-1:0]  pop;
  logic [IDXW-1:0] lo_bit;
  logic            has_one;

  always_comb begin
    pop     = '0;
    lo_bit  = '0;
    has_one = 1'b0;
    for (int unsigned i = 0; i < REQ_DATA_WIDTH; i++) begin
      pop = pop + NBW'(s1_eff[i]);
      if (s1_eff[i] && !has_one) begin
        lo_bit  = IDXW'(i);
        has_one = 1'b1;
      end
    end
  end

  logic                       s2_valid;
  logic [NBW-1:0]             s2_pop;
  logic [IDXW-1:0]            s2_bit;
  logic                       s2_has_one;
  logic [RESP_DATA_WIDTH-1:0] s2_beat;
  logic                       s2_op;
  logic                       s2_end;
  logic [REQ_ADDR_WIDTH-1:0]  s2_addr;
  logic [RESP_DATA_WIDTH-1:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_pop     <= '0;
      s2_bit     <= '0;
      s2_has_one <= 1'b0;
      s2_beat    <= '0;
      s2_op      <= 1'b0;
      s2_end     <= 1'b0;
      s2_addr    <= '0;
      beat_cnt   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pop     <= pop;
        s2_bit     <= lo_bit;
        s2_has_one <= has_one;
        s2_beat    <= beat_cnt;
        s2_op      <= s1_op;
        s2_end     <= s1_end;
        s2_addr    <= s1_addr;
        beat_cnt   <= s1_end ? '0 : beat_cnt + RESP_DATA_WIDTH'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // S3: accumulate; result is re-registered once more so out_valid lands
  // on the third edge after the end beat is sampled.
  // ---------------------------------------------------------------------
  logic [RESP_DATA_WIDTH-1:0] count;
  logic [RESP_DATA_WIDTH-1:0] idx;
  logic                       found;
  logic [RESP_DATA_WIDTH-1:0] next_count;
  logic [RESP_DATA_WIDTH-1:0] next_idx;
  logic                       next_found;
  logic [RESP_DATA_WIDTH-1:0] result;

  always_comb begin
    next_count = count + RESP_DATA_WIDTH'(s2_pop);
    next_idx   = idx;
    next_found = found;
    if (!found && s2_has_one) begin
      next_idx   = s2_beat * RESP_DATA_WIDTH'(REQ_DATA_WIDTH) + RESP_DATA_WIDTH'(s2_bit);
      next_found = 1'b1;
    end
    if (s2_op) begin
      result = next_found ? next_idx : '1;
    end else begin
      result = next_count;
    end
  end

  logic                       res_valid;
  logic [RESP_DATA_WIDTH-1:0] res_vec;
  logic [REQ_ADDR_WIDTH-1:0]  res_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      idx       <= '0;
      found     <= 1'b0;
      res_valid <= 1'b0;
      res_vec   <= '0;
      res_addr  <= '0;
    end else begin
      res_valid <= 1'b0;
      res_vec   <= '0;
      if (s2_valid) begin
        if (s2_end) begin
          res_valid <= 1'b1;
          res_vec   <= result;
          res_addr  <= s2_addr;
          count     <= '0;
          idx       <= '0;
          found     <= 1'b0;
        end else begin
          count <= next_count;
          idx   <= next_idx;
          found <= next_found;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_addr  <= '0;
    end else begin
      out_valid <= res_valid;
      out_vec   <= res_vec;
      out_addr  <= res_addr;
    end
  end

endmodule

// File: tb/tb_vmask_reduce.sv
// Testbench for vmask_reduce: directed cases plus a randomized burst, checked
// through a scoreboard queue of expected (value, address, cycle) entries.
module tb_vmask_reduce;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_end;
  logic        in_op;
  logic [63:0] in_m0;
  logic [63:0] in_v0;
  logic        in_vm;
  logic [6:0]  in_nbits;
  logic [31:0] in_addr;
  logic [63:0] out_vec;
  logic [31:0] out_addr;
  logic        out_valid;

  vmask_reduce #(
    .REQ_DATA_WIDTH (64),
    .RESP_DATA_WIDTH(64),
    .REQ_ADDR_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_end   (in_end),
    .in_op    (in_op),
    .in_m0    (in_m0),
    .in_v0    (in_v0),
    .in_vm    (in_vm),
    .in_nbits (in_nbits),
    .in_addr  (in_addr),
    .out_vec  (out_vec),
    .out_addr (out_addr),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] vec;
    logic [31:0] addr;
    int unsigned cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_vec", out_vec, e.vec);
          check("out_addr", 64'(out_addr), 64'(e.addr));
          check("latency_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("idle_vec_zero", out_vec, 64'd0);
      end
    end
  end

  // Drive one beat; it is sampled on the next rising edge. The expected
  // result is queued for end beats, due three edges after that sampling edge.
  task automatic beat(input bit op, input logic [63:0] m0, input logic [63:0] v0,
                      input bit vm, input int nbits, input bit last,
                      input logic [31:0] addr, input logic [63:0] exp_vec);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_m0    = m0;
    in_v0    = v0;
    in_vm    = vm;
    in_nbits = 7'(nbits);
    in_end   = last;
    in_addr  = addr;
    @(posedge clk);
    #1;
    if (last) begin
      e.vec  = exp_vec;
      e.addr = addr;
      e.cyc  = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_end   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0;
    in_end   = 1'b0;
    while (q.size() != 0 && k < 30) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference model pieces for the randomized burst.
  function automatic logic [63:0] model_eff(input logic [63:0] m0, input logic [63:0] v0,
                                            input bit vm, input int nbits);
    int n;
    logic [63:0] tmask;
    n = (nbits > 64) ? 64 : nbits;
    tmask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    return m0 & (vm ? 64'hFFFF_FFFF_FFFF_FFFF : v0) & tmask;
  endfunction

  function automatic int model_low(input logic [63:0] e);
    for (int i = 63; i >= 0; i--) begin
      if (e[i]) model_low = i;
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_end   = 1'b0;
    in_op    = 1'b0;
    in_m0    = '0;
    in_v0    = '0;
    in_vm    = 1'b1;
    in_nbits = '0;
    in_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_vec", out_vec, 64'd0);
    check("reset_out_addr", 64'(out_addr), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single-beat cpop
    beat(0, 64'hFF00_0000_0000_00F1, '0, 1, 64, 1, 32'h100, 64'd13);
    // Multi-beat cpop with bubbles
    beat(0, '1, '0, 1, 64, 0, 32'h1F0, 64'd0);
    idle(2);
    beat(0, '1, '0, 1, 64, 0, 32'h1F4, 64'd0);
    beat(0, '1, '0, 1, 10, 1, 32'h200, 64'd138);
    // Masked vs unmasked
    beat(0, '1, 64'h5555_5555_5555_5555, 0, 64, 1, 32'h300, 64'd32);
    beat(0, '1, 64'h5555_5555_5555_5555, 1, 64, 1, 32'h304, 64'd64);
    // vfirst
    beat(1, 64'h0,   '0, 1, 64, 0, 32'h3F0, 64'd0);
    beat(1, 64'h100, '0, 1, 64, 0, 32'h3F4, 64'd0);
    beat(1, 64'h1,   '0, 1, 64, 1, 32'h400, 64'd72);
    beat(1, 64'h0,   '0, 1, 64, 0, 32'h3F8, 64'd0);
    beat(1, 64'h0,   '0, 1, 64, 1, 32'h404, 64'hFFFF_FFFF_FFFF_FFFF);
    beat(1, 64'h100, '0, 1, 8,  1, 32'h408, 64'hFFFF_FFFF_FFFF_FFFF);
    // Back-to-back single-beat ops
    beat(0, 64'hF,  '0, 1, 64, 1, 32'h500, 64'd4);
    beat(1, 64'h10, '0, 1, 64, 1, 32'h504, 64'd4);
    // nbits = 0 still advances the beat index
    beat(1, '1, '0, 1, 0,  0, 32'h5F0, 64'd0);
    beat(1, 64'h1, '0, 1, 64, 1, 32'h600, 64'd64);
    // Out-of-range nbits clamps to full width
    beat(0, '1, '0, 1, 100, 1, 32'h604, 64'd64);
    // Masked vfirst
    beat(1, '1, 64'hFFFF_FFFF_FFFF_0000, 0, 64, 1, 32'h608, 64'd16);
    drain();

    // Reset mid-operation: partial beats are discarded
    beat(0, '1, '0, 1, 64, 0, 32'h700, 64'd0);
    beat(0, '1, '0, 1, 64, 0, 32'h704, 64'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_vec", out_vec, 64'd0);
    check("midrst_out_addr", 64'(out_addr), 64'd0);
    rst = 1'b0;
    beat(0, 64'h3, '0, 1, 64, 1, 32'h708, 64'd2);
    drain();

    // Randomized burst against the reference model
    for (int op_i = 0; op_i < 25; op_i++) begin
      bit          op;
      int          nb;
      logic [63:0] cnt;
      logic [63:0] fidx;
      bit          found;
      logic [31:0] addr;
      op    = 1'($urandom_range(0, 1));
      nb    = $urandom_range(1, 4);
      cnt   = '0;
      fidx  = '0;
      found = 1'b0;
      addr  = $urandom;
      for (int b = 0; b < nb; b++) begin
        logic [63:0] m0;
        logic [63:0] v0;
        logic [63:0] e;
        bit          vm;
        int          nbits;
        logic [63:0] expv;
        m0 = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) m0 = '0;
        v0    = {$urandom, $urandom};
        vm    = 1'($urandom_range(0, 1));
        nbits = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 70) : 64;
        e     = model_eff(m0, v0, vm, nbits);
        cnt   = cnt + 64'($countones(e));
        if (!found && e != 0) begin
          found = 1'b1;
          fidx  = 64'(b) * 64 + 64'(model_low(e));
        end
        expv = op ? (found ? fidx : 64'hFFFF_FFFF_FFFF_FFFF) : cnt;
        beat(op, m0, v0, vm, nbits, b == nb - 1, addr, expv);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
